// File: rtl/simon_pkg.sv
// Shared Simon game types: colour encoding, LED one-hot helper, LFSR step.
package simon_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_t;

  // Player FSM states
  typedef enum logic [2:0] {
    S_IDLE,
    S_APPEND,
    S_ON,
    S_OFF,
    S_DONE
  } play_state_t;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] onehot(input color_t c);
    return 4'b0001 << c;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// Free-running 16-bit Galois LFSR; an all-zero seed would lock up, so it maps to 1.
module simon_lfsr16
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] q_q;

  // Advance every cycle regardless of what the player is doing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= SEED_EFF;
    else     q_q <= lfsr_next(q_q);
  end

  assign q = q_q;

endmodule

// File: rtl/simon_sequence_player.sv
// Simon sequence player: grows the colour sequence by one random colour per
// start, then plays it back as timed one-hot LED flashes.
module simon_sequence_player
  import simon_pkg::*;
#(
  parameter int          MAX_LEN    = 32,
  parameter int          ON_CYCLES  = 25000000,
  parameter int          OFF_CYCLES = 12500000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           clear,
  input  logic [$clog2(MAX_LEN)-1:0]     rd_idx,
  output logic [1:0]                     rd_color,
  output logic [3:0]                     led,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(MAX_LEN+1)-1:0]   seq_len,
  output logic                           seq_full
);

  localparam int IW   = $clog2(MAX_LEN);
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  logic [15:0]   lfsr;
  logic          lfsr_unused;
  play_state_t   state_q;
  logic [LW-1:0] len_q, idx_q, idx_nxt;
  logic [TW-1:0] tmr_q;
  logic [3:0]    led_q;
  logic          busy_q, done_q;
  logic [1:0]    mem_q [MAX_LEN];
  logic          full;
  logic [1:0]    first_col;

  simon_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  // Only the low two bits pick a colour
  assign lfsr_unused = ^lfsr[15:2];

  assign full    = (len_q == LW'(MAX_LEN));
  assign idx_nxt = idx_q + 1'b1;
  // First flash is loaded on the same edge that writes mem[0] when the
  // sequence was empty, so forward the colour being stored.
  assign first_col = (len_q == '0) ? lfsr[1:0] : mem_q[0];

  // Register-file write of the appended colour; contents need no reset
  always_ff @(posedge clk) begin
    if (!clear && state_q == S_APPEND && !full)
      mem_q[len_q[IW-1:0]] <= lfsr[1:0];
  end

  // Playback FSM with shared down-counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state_q <= S_IDLE;
        len_q   <= '0;
        led_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_APPEND;
              busy_q  <= 1'b1;
            end
          end
          S_APPEND: begin
            if (!full) len_q <= len_q + 1'b1;
            idx_q   <= '0;
            tmr_q   <= ON_LOAD;
            led_q   <= onehot(color_t'(first_col));
            state_q <= S_ON;
          end
          S_ON: begin
            if (tmr_q == '0) begin
              tmr_q   <= OFF_LOAD;
              led_q   <= '0;
              state_q <= S_OFF;
            end else begin
              tmr_q <= tmr_q - 1'b1;
            end
          end
          S_OFF: begin
            if (tmr_q == '0) begin
              if (idx_nxt == len_q) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                idx_q   <= idx_nxt;
                tmr_q   <= ON_LOAD;
                led_q   <= onehot(color_t'(mem_q[idx_nxt[IW-1:0]]));
                state_q <= S_ON;
              end
            end else begin
              tmr_q <= tmr_q - 1'b1;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_color = mem_q[rd_idx];
  assign led      = led_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign seq_len  = len_q;
  assign seq_full = full;

endmodule

// File: tb/tb_simon_sequence_player.sv
// Scoreboard bench for simon_sequence_player: driver pushes expected flashes
// and done cycles, a negedge monitor pops and compares them.
module tb_simon_sequence_player;

  localparam int          ON   = 4;
  localparam int          OFF  = 2;
  localparam int          ML   = 4;
  localparam int          P    = ON + OFF;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, clear = 1'b0;
  logic [1:0] rd_idx = '0;
  logic [1:0] rd_color;
  logic [3:0] led;
  logic       busy, done, seq_full;
  logic [2:0] seq_len;

  simon_sequence_player #(
    .MAX_LEN(ML), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .rd_idx(rd_idx),
    .rd_color(rd_color), .led(led), .busy(busy), .done(done),
    .seq_len(seq_len), .seq_full(seq_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR straight from the polynomial: value during each cycle
  logic [15:0] rl;
  always @(posedge clk or posedge rst) begin
    if (rst) rl <= SEED;
    else     rl <= (rl >> 1) ^ (rl[0] ? 16'hB400 : 16'h0000);
  end

  typedef struct { int col; int at; } flash_t;
  int     mseq[$];
  flash_t fq[$];
  int     dq[$];
  int     clr_cyc = -100;
  int     n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every flash onset, length and done pulse against the queues
  logic [3:0] lp = '0;
  int         run = 0;
  flash_t     mf;
  always @(negedge clk) begin
    if (rst) begin
      lp  = '0;
      run = 0;
    end else begin
      if (led != 0 && lp == 0) begin
        if (fq.size() == 0) chk("unexpected_flash", led, 0);
        else begin
          mf = fq.pop_front();
          chk("flash_led", led, 32'd1 << mf.col);
          chk("flash_cycle", cyc, mf.at);
        end
        run = 1;
      end else if (led != 0) begin
        if (led != lp) chk("led_stable", led, lp);
        run++;
      end else if (lp != 0) begin
        if (cyc != clr_cyc + 1) chk("flash_len", run, ON);
        run = 0;
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else                chk("done_cycle", cyc, dq.pop_front());
      end
      lp = led;
    end
  end

  // One start; optionally a stray start mid-play, or a clear in flash abort_at
  task automatic do_start(input bit inject, input int abort_at);
    int k, len, dcyc, inj, ab, bcnt;
    k = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_T1", busy, 1);
    if (mseq.size() < ML) mseq.push_back(int'(rl[1:0]));
    len = mseq.size();
    for (int i = 0; i < len; i++) fq.push_back('{col: mseq[i], at: k + 2 + i * P});
    dcyc = k + 2 + len * P;
    dq.push_back(dcyc);
    tick();
    chk("seq_len_T2", seq_len, len);
    inj  = inject ? int'($urandom_range(k + 2, dcyc - 1)) : -1;
    ab   = (abort_at >= 0) ? k + 2 + abort_at * P + 1 : -1;
    bcnt = 1;
    while (cyc < dcyc) begin
      if (busy) bcnt++;
      start = (cyc == inj);
      if (cyc == ab) begin
        clear   = 1'b1;
        clr_cyc = cyc;
        tick();
        start = 1'b0;
        clear = 1'b0;
        chk("clr_led", led, 0);
        chk("clr_busy", busy, 0);
        chk("clr_len", seq_len, 0);
        fq.delete();
        dq.delete();
        mseq.delete();
        repeat (P + 4) tick();
        chk("clr_idle_busy", busy, 0);
        chk("clr_idle_len", seq_len, 0);
        return;
      end
      tick();
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_span", bcnt + 1, 2 + len * P);
    tick();
    chk("done_low", done, 0);
    chk("busy_low", busy, 0);
    chk("seq_full", seq_full, mseq.size() == ML);
    for (int i = 0; i < len; i++) begin
      rd_idx = 2'(i);
      #1;
      chk("rd_color", rd_color, mseq[i]);
    end
    tick();
  endtask

  initial begin
    tick();
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len", seq_len, 0);
    tick();
    rst = 1'b0;
    tick();

    // Three starts, then two more to overfill a length-4 sequence
    for (int s = 0; s < 5; s++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_start(($urandom_range(0, 1) == 1), -1);
    end
    chk("full_len", seq_len, ML);

    // Clear in the second cycle of the second flash
    do_start(1'b0, 1);

    // start and clear together are both dropped in favour of clear
    do_start(1'b0, -1);
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    mseq.delete();
    chk("sc_busy", busy, 0);
    chk("sc_len", seq_len, 0);
    tick();
    chk("sc_busy2", busy, 0);
    chk("sc_led", led, 0);

    // Asynchronous reset during the first flash
    do_start(1'b0, -1);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (mseq.size() < ML) mseq.push_back(int'(rl[1:0]));
    for (int i = 0; i < mseq.size(); i++) fq.push_back('{col: mseq[i], at: cyc + 1 + i * P});
    dq.push_back(cyc + 1 + mseq.size() * P);
    tick();
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("arst_led", led, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_len", seq_len, 0);
    fq.delete();
    dq.delete();
    mseq.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_len", seq_len, 0);
    do_start(1'b1, -1);

    repeat (3) tick();
    chk("flash_q_empty", fq.size(), 0);
    chk("done_q_empty", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
